// File: rtl/memoria_instrucoes_carregavel.sv
// Loadable instruction memory.
//
// After reset (or a reload request while running) every word is overwritten with
// HALT_WORD, one word per cycle. The memory then accepts a program over a
// valid/ready port starting at index LOAD_BASE. Once the program is complete, it
// serves registered fetches to the core with one cycle of latency.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   load_valid      loader presents load_data this cycle
//   load_ready      memory is in the load phase and accepting words
//   load_data       word to store at the current load pointer
//   load_last       marks the final word of the program (only with load_valid)
//   reload          pulse while running: clear memory and wait for a new program
//   endereco        fetch address
//   read_enable     fetch request
//   instrucao       fetched word (holds while no fetch is made)
//   instrucao_valid instrucao was updated by a fetch on the previous edge
//   ready           memory is running and serving fetches
//   program_length  number of words accepted by the loader
//   fault           sticky flag: a fetch hit an address at or beyond DEPTH
module memoria_instrucoes_carregavel #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DEPTH      = 64,
  parameter int unsigned           LOAD_BASE  = 1,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'h9000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  reload,
  input  logic [ADDR_WIDTH-1:0] endereco,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic                  instrucao_valid,
  output logic                  ready,
  output logic [ADDR_WIDTH:0]   program_length,
  output logic                  fault
);

  localparam int unsigned         MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MemAw-1:0]    LastIdx  = MemAw'(DEPTH - 1);
  localparam logic [MemAw-1:0]    BaseIdx  = MemAw'(LOAD_BASE);
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LenMax   = (ADDR_WIDTH + 1)'(DEPTH - LOAD_BASE);

  typedef enum logic [1:0] {StClear, StLoad, StRun} state_t;

  state_t                  state;
  logic [MemAw-1:0]        clear_ptr;
  logic [MemAw-1:0]        load_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    load_fire;
  logic                    mem_we;
  logic [MemAw-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    fetch_oor;
  logic [MemAw-1:0]        rd_idx;

  // The write port is shared by the clear sweep and the loader; the two phases
  // never overlap, and neither overlaps with fetches in RUN.
  always_comb begin
    load_fire = (state == StLoad) && load_valid && load_ready;
    mem_we    = 1'b0;
    mem_waddr = clear_ptr;
    mem_wdata = HALT_WORD;
    if (!reset) begin
      if (state == StClear) begin
        mem_we = 1'b1;
      end else if (load_fire) begin
        mem_we    = 1'b1;
        mem_waddr = load_ptr;
        mem_wdata = load_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // All ADDR_WIDTH bits take part in the range test; only the low bits index.
  always_comb begin
    fetch_oor = ({1'b0, endereco} >= DepthLim);
    rd_idx    = endereco[MemAw-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= StClear;
      clear_ptr       <= '0;
      load_ptr        <= BaseIdx;
      instrucao       <= HALT_WORD;
      instrucao_valid <= 1'b0;
      fault           <= 1'b0;
      load_ready      <= 1'b0;
      ready           <= 1'b0;
      program_length  <= '0;
    end else begin
      unique case (state)
        StClear: begin
          instrucao_valid <= 1'b0;
          clear_ptr       <= clear_ptr + 1'b1;
          if (clear_ptr == LastIdx) begin
            state      <= StLoad;
            clear_ptr  <= '0;
            load_ready <= 1'b1;
          end
        end
        StLoad: begin
          instrucao_valid <= 1'b0;
          if (load_fire) begin
            load_ptr <= load_ptr + 1'b1;
            if (program_length < LenMax) begin
              program_length <= program_length + 1'b1;
            end
            // The last physical slot ends the load even without load_last.
            if (load_last || (load_ptr == LastIdx)) begin
              state      <= StRun;
              load_ready <= 1'b0;
              ready      <= 1'b1;
            end
          end
        end
        StRun: begin
          if (reload) begin
            // Reload takes priority over a fetch issued in the same cycle.
            state           <= StClear;
            clear_ptr       <= '0;
            load_ptr        <= BaseIdx;
            program_length  <= '0;
            fault           <= 1'b0;
            ready           <= 1'b0;
            instrucao_valid <= 1'b0;
          end else if (read_enable) begin
            instrucao_valid <= 1'b1;
            if (fetch_oor) begin
              instrucao <= HALT_WORD;
              fault     <= 1'b1;
            end else begin
              instrucao <= mem[rd_idx];
            end
          end else begin
            instrucao_valid <= 1'b0;
          end
        end
        default: begin
          state <= StClear;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_instrucoes_carregavel.sv
module tb_memoria_instrucoes_carregavel;

  localparam int          DEPTH = 64;
  localparam int          BASE  = 1;
  localparam logic [31:0] HALT  = 32'h9000_0000;

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic        load_valid  = 1'b0;
  logic        load_last   = 1'b0;
  logic        reload      = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] load_data   = '0;
  logic [9:0]  endereco    = '0;
  logic        load_ready;
  logic [31:0] instrucao;
  logic        instrucao_valid;
  logic        ready;
  logic [10:0] program_length;
  logic        fault;

  int total = 0;
  int bad   = 0;

  // Reference model: the accepted program as a list, plus the expected
  // registered fetch output and sticky fault.
  logic [31:0] exp_prog[$];
  logic [31:0] prog_q[$];
  logic [31:0] m_instr = HALT;
  logic        m_fault = 1'b0;

  memoria_instrucoes_carregavel dut (
    .clock          (clock),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_data      (load_data),
    .load_last      (load_last),
    .reload         (reload),
    .endereco       (endereco),
    .read_enable    (read_enable),
    .instrucao      (instrucao),
    .instrucao_valid(instrucao_valid),
    .ready          (ready),
    .program_length (program_length),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address 0 is never loaded; loaded words occupy BASE .. BASE+len-1.
  function automatic logic [31:0] exp_word(input int addr);
    if (addr < BASE || addr >= DEPTH) return HALT;
    if (addr - BASE < exp_prog.size()) return exp_prog[addr - BASE];
    return HALT;
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_instr = HALT;
    m_fault = 1'b0;
    exp_prog.delete();
    check({tag, "_instr"}, instrucao, HALT);
    check({tag, "_valid"}, instrucao_valid, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_lrdy"}, load_ready, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_plen"}, program_length, 0);
  endtask

  // Called right after the edge that entered CLEAR.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (load_ready !== 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    check({tag, "_clear_cycles"}, cnt, DEPTH);
    check({tag, "_ready_in_load"}, ready, 0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    m_fault = 1'b0;
    exp_prog.delete();
    check({tag, "_valid"}, instrucao_valid, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_ready"}, ready, 0);
    wait_clear(tag);
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid.
  task automatic load_prog(input bit use_last, input int mode, input string tag);
    int idx = 0;
    int cyc = 0;
    bit v;
    bit ph = 1'b1;
    bit done = 1'b0;
    exp_prog.delete();
    while (!done && idx < prog_q.size() && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ph; ph = ~ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_valid = v;
      load_data  = prog_q[idx];
      load_last  = use_last && (idx == prog_q.size() - 1);
      check({tag, "_lrdy"}, load_ready, 1);
      tick();
      if (v) begin
        exp_prog.push_back(prog_q[idx]);
        idx++;
        if (load_last || exp_prog.size() == DEPTH - BASE) done = 1'b1;
      end
      cyc++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check({tag, "_ready"}, ready, 1);
    check({tag, "_lrdy_run"}, load_ready, 0);
    check({tag, "_plen"}, program_length, exp_prog.size());
  endtask

  task automatic fetch_cycle(input int addr, input bit re, input string tag);
    endereco    = 10'(addr);
    read_enable = re;
    tick();
    read_enable = 1'b0;
    if (re) begin
      m_instr = exp_word(addr);
      if (addr >= DEPTH) m_fault = 1'b1;
    end
    check({tag, "_valid"}, instrucao_valid, re);
    check({tag, "_instr"}, instrucao, m_instr);
    check({tag, "_fault"}, fault, m_fault);
  endtask

  initial begin
    // Reset, clear length, idle in LOAD with fetches ignored.
    do_reset("rst");
    wait_clear("clr0");
    endereco    = 10'd100;
    read_enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    read_enable = 1'b0;
    check("idle_valid", instrucao_valid, 0);
    check("idle_fault", fault, 0);
    check("idle_ready", ready, 0);
    check("idle_lrdy", load_ready, 1);
    prog_q = '{HALT, HALT};
    load_prog(1'b1, 0, "ld_halt");
    for (int a = 0; a < DEPTH; a++) fetch_cycle(a, 1'b1, "all_halt");

    // Three-word program with toggled valid.
    do_reload("rl1");
    prog_q = '{32'h8000_0019, 32'hC840_0000, 32'h9000_0000};
    load_prog(1'b1, 1, "ld3");
    for (int a = 1; a <= 4; a++) fetch_cycle(a, 1'b1, "f3");
    fetch_cycle(2, 1'b0, "hold");

    // Out-of-range fetch and sticky fault.
    fetch_cycle(100, 1'b1, "oor");
    fetch_cycle(2, 1'b1, "sticky");
    fetch_cycle(1, 1'b1, "sticky2");

    // Reload together with a fetch: reload wins.
    endereco    = 10'd1;
    reload      = 1'b1;
    read_enable = 1'b1;
    tick();
    reload      = 1'b0;
    read_enable = 1'b0;
    m_fault     = 1'b0;
    exp_prog.delete();
    check("rl_re_valid", instrucao_valid, 0);
    check("rl_re_fault", fault, 0);
    check("rl_re_instr", instrucao, m_instr);
    wait_clear("rl_re");

    // 70 words without load_last: only DEPTH-BASE are taken.
    prog_q.delete();
    for (int i = 0; i < 70; i++) prog_q.push_back($urandom);
    load_prog(1'b0, 2, "ld70");
    for (int i = DEPTH - BASE; i < 70; i++) begin
      load_valid = 1'b1;
      load_data  = prog_q[i];
      tick();
      check("extra_lrdy", load_ready, 0);
      check("extra_plen", program_length, DEPTH - BASE);
    end
    load_valid = 1'b0;
    fetch_cycle(1, 1'b1, "f70");
    fetch_cycle(63, 1'b1, "f70");
    fetch_cycle(64, 1'b1, "f70_oor");

    // Short program after a long one: old words must be gone.
    do_reload("rl2");
    prog_q = '{$urandom, $urandom};
    load_prog(1'b1, 0, "ld2");
    for (int a = 0; a <= 10; a++) fetch_cycle(a, 1'b1, "old_gone");

    // Randomised rounds.
    for (int r = 0; r < 3; r++) begin
      int n;
      do_reload("rl_rand");
      n = int'($urandom_range(1, 20));
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back($urandom);
      load_prog(1'b1, 2, "ld_rand");
      for (int k = 0; k < 30; k++) begin
        int addr;
        bit re;
        re   = 1'($urandom_range(0, 1));
        addr = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, DEPTH - 1))
                                          : int'($urandom_range(DEPTH, 1023));
        fetch_cycle(addr, re, "rand");
      end
    end

    // Reset in the middle of a load; reload outside RUN is ignored.
    do_reset("rst2");
    wait_clear("clr2");
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("rl_load_lrdy", load_ready, 1);
    check("rl_load_ready", ready, 0);
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA5A5_0000 + 32'(i);
      tick();
      check("part_plen", program_length, i + 1);
    end
    load_data = 32'hA5A5_0002;
    do_reset("rst_mid");
    load_valid = 1'b0;
    wait_clear("clr3");
    prog_q = '{32'h1234_5678};
    load_prog(1'b1, 0, "ld1");
    for (int a = 0; a <= 3; a++) fetch_cycle(a, 1'b1, "after_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
